// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder: folds E0/F0 prefixes into {ext, brk, code} key events
// and queues them in a show-ahead FIFO drained through a valid/ready port.
module ps2_key_decoder #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = 50000,
    parameter int unsigned TO_W       = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic [9:0]                    ev_data,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic                          timeout_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [7:0]  CODE_EXT = 8'hE0;
    localparam logic [7:0]  CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_E0   = 2'd1,
        S_F0   = 2'd2,
        S_E0F0 = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [TO_W-1:0] to_cnt;
    logic            is_ext;
    logic            is_brk;
    logic            emit;
    logic            tmo_hit;
    logic [9:0]      emit_word;

    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            full;
    logic            pop;
    logic            do_push;
    logic            drop;

    // Prefix decode: a non-prefix byte always emits, tagged by the prefixes seen so far.
    always_comb begin
        is_ext     = rx_data == CODE_EXT;
        is_brk     = rx_data == CODE_BRK;
        emit       = 1'b0;
        emit_word  = {(state == S_E0) || (state == S_E0F0),
                      (state == S_F0) || (state == S_E0F0),
                      rx_data};
        state_next = state;
        tmo_hit    = 1'b0;
        if (rx_valid) begin
            if (is_ext) begin
                unique case (state)
                    S_IDLE:  state_next = S_E0;
                    S_E0:    state_next = S_E0;
                    S_F0:    state_next = S_E0F0;
                    default: state_next = S_E0F0;
                endcase
            end else if (is_brk) begin
                unique case (state)
                    S_IDLE:  state_next = S_F0;
                    S_E0:    state_next = S_E0F0;
                    S_F0:    state_next = S_F0;
                    default: state_next = S_E0F0;
                endcase
            end else begin
                emit       = 1'b1;
                state_next = S_IDLE;
            end
        end else if ((state != S_IDLE) && (to_cnt == TO_W'(TIMEOUT))) begin
            tmo_hit    = 1'b1;
            state_next = S_IDLE;
        end
    end

    // Prefix FSM with its abort timer; an arriving byte always beats the timeout.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            timeout_err <= tmo_hit;
            if (rx_valid || (state == S_IDLE) || tmo_hit) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    // FIFO control: a pop in the same cycle frees the slot a full-FIFO push needs.
    always_comb begin
        full       = count == CW'(FIFO_DEPTH);
        pop        = ev_valid && ev_ready;
        do_push    = emit && (!full || pop);
        drop       = emit && full && !pop;
        count_next = count;
        unique case ({do_push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ev_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            count    <= count_next;
            ev_valid <= count_next != '0;
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (overflow_clr) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage has no reset; contents are only observable behind ev_valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= emit_word;
        end
    end

    assign ev_data    = mem[rd_ptr];
    assign fifo_count = count;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed and scoreboard-checked bench for ps2_key_decoder.
module tb_ps2_key_decoder;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 20;
    localparam int unsigned TOW   = 8;

    logic       clk;
    logic       resetn;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] ev_data;
    logic       ev_valid;
    logic       ev_ready;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       overflow_clr;
    logic       timeout_err;

    int n_tests;
    int n_fail;

    ps2_key_decoder #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO),
        .TO_W       (TOW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .ev_data      (ev_data),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [9:0] exp);
        check({tag, "_valid"}, 32'(ev_valid), 32'd1);
        check({tag, "_data"}, 32'(ev_data), 32'(exp));
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] q[$];
        logic       m_ext;
        logic       m_brk;
        logic       m_ovf;
        int         first_seen;
        int         pulses;

        n_tests = 0;
        n_fail  = 0;
        resetn = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        ev_ready = 1'b0; overflow_clr = 1'b0;
        do_reset();

        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_tmo", 32'(timeout_err), 32'd0);

        // Prefix folding, each event visible one cycle after its last byte
        send_byte(8'h1C);
        check("make_cnt", 32'(fifo_count), 32'd1);
        pop_expect("make", 10'h01C);
        send_byte(8'hE0); send_byte(8'h75);
        pop_expect("ext_make", 10'h275);
        send_byte(8'hF0); send_byte(8'h1C);
        pop_expect("brk", 10'h11C);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        pop_expect("ext_brk", 10'h375);
        send_byte(8'hF0); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
        pop_expect("f0e0_brk", 10'h314);
        check("empty_after", 32'(ev_valid), 32'd0);

        // Overflow: nine pushes into eight slots
        for (int i = 0; i < 9; i++) send_byte(8'(8'h10 + i));
        check("ovf_cnt", 32'(fifo_count), 32'd8);
        check("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) pop_expect($sformatf("drain%0d", i), 10'(8'h10 + i));
        check("drain_cnt", 32'(fifo_count), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        check("empty_pop_cnt", 32'(fifo_count), 32'd0);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Full FIFO with simultaneous push and pop loses nothing
        for (int i = 0; i < 8; i++) send_byte(8'(8'h20 + i));
        check("full_cnt", 32'(fifo_count), 32'd8);
        @(negedge clk);
        rx_data = 8'h28; rx_valid = 1'b1; ev_ready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; ev_ready = 1'b0;
        check("pp_cnt", 32'(fifo_count), 32'd8);
        check("pp_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 9; i++) pop_expect($sformatf("pp%0d", i), 10'(8'h20 + i));

        // Prefix timeout
        send_byte(8'hE0);
        first_seen = -1;
        pulses = 0;
        for (int i = 1; i <= int'(TMO) + 10; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                pulses++;
                if (first_seen < 0) first_seen = i;
            end
        end
        check("tmo_pulses", 32'(pulses), 32'd1);
        check("tmo_early", 32'(first_seen >= int'(TMO)), 32'd1);
        check("tmo_late", 32'(first_seen <= int'(TMO) + 1), 32'd1);
        check("tmo_noev", 32'(ev_valid), 32'd0);
        send_byte(8'h1C);
        pop_expect("after_tmo", 10'h01C);

        // Reset in the middle of a prefix sequence
        send_byte(8'hE0); send_byte(8'hF0);
        do_reset();
        send_byte(8'h75);
        check("mid_rst_cnt", 32'(fifo_count), 32'd1);
        pop_expect("mid_rst", 10'h075);

        // Random stream against a reference queue
        m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
        q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic       pop;
            logic [7:0] b;
            logic       v;
            @(negedge clk);
            v = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 5))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                default: b = 8'($urandom_range(0, 8'hDF));
            endcase
            rx_data  = b;
            rx_valid = v;
            ev_ready = ($urandom_range(0, 3) == 0);
            check("rnd_valid", 32'(ev_valid), 32'(q.size() != 0));
            if (cyc % 16 == 0) check("rnd_cnt", 32'(fifo_count), 32'(q.size()));
            pop = ev_ready && (q.size() != 0);
            if (pop) begin
                check("rnd_data", 32'(ev_data), 32'(q[0]));
                void'(q.pop_front());
            end
            if (v) begin
                if (b == 8'hE0) m_ext = 1'b1;
                else if (b == 8'hF0) m_brk = 1'b1;
                else begin
                    if (q.size() < int'(DEPTH)) q.push_back({m_ext, m_brk, b});
                    else m_ovf = 1'b1;
                    m_ext = 1'b0;
                    m_brk = 1'b0;
                end
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        ev_ready = 1'b0;
        check("rnd_ovf", 32'(overflow), 32'(m_ovf));
        check("rnd_end_cnt", 32'(fifo_count), 32'(q.size()));
        while (q.size() != 0) begin
            pop_expect("rnd_drain", q[0]);
            void'(q.pop_front());
        end
        check("rnd_empty", 32'(ev_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
